// File: rtl/seg7_ctrl_pkg.sv
// Shared definitions for the seg7 scroll controller: register map,
// controller states, CTRL bit positions, blank word and hex font.
package seg7_ctrl_pkg;

  // Register map
  localparam logic [1:0] ADDR_MSG    = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // Controller state; the encoding is what STATUS[4:3] reports
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATIC = 2'd1,
    ST_SCROLL = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // CTRL bit positions
  localparam int CTRL_RUN    = 0;
  localparam int CTRL_SCROLL = 1;
  localparam int CTRL_WRAP   = 2;
  localparam int CTRL_BLINK  = 3;

  // All segments off (active-low), decimal point held at 0
  localparam logic [31:0] BLANK = 32'h7F7F7F7F;

  // Active-low segments g..a for hex digits, entry 15 first
  localparam logic [15:0][6:0] FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational hex nibble to active-low 7-segment pattern (bit6=g .. bit0=a).
module seg7_hex_font
  import seg7_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = FONT[nibble];

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// Avalon-MM slave that drives a 4-digit 7-segment bank from an 8-nibble
// message: blank, static, scrolling (wrap or stop-and-hold), plus STATUS.
// Optional feature: define SEG7_BLINK_EN to add CTRL[3] blink in STATIC/HOLD.
module seg7_scroll_ctrl
  import seg7_ctrl_pkg::*;
#(
  parameter int          PERIOD_W      = 24,
  parameter logic [31:0] RESET_PATTERN = 32'h40404040
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_port
);

`ifdef SEG7_BLINK_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
`else
  localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

  logic [31:0]         msg_reg,    msg_next;
  logic [3:0]          ctrl_reg,   ctrl_next;
  logic [PERIOD_W-1:0] period_reg, period_next;
  logic [PERIOD_W-1:0] tick_reg,   tick_next;
  logic [2:0]          offset_reg, offset_next;
  state_t              state_reg,  state_next;
  logic                done_reg,   done_next;
  logic                phase_reg,  phase_next;
  logic                disp_load;
  logic [31:0]         disp_word;
  logic [31:0]         out_next;

  logic wr_en, wr_msg, wr_ctrl, wr_period, period_last;

  assign wr_en       = chipselect && !write_n;
  assign wr_msg      = wr_en && (address == ADDR_MSG);
  assign wr_ctrl     = wr_en && (address == ADDR_CTRL);
  assign wr_period   = wr_en && (address == ADDR_PERIOD);
  assign period_last = (period_reg != '0) && (tick_reg == period_reg - PERIOD_W'(1));

  // Next-state: bus writes take priority over tick-driven advances
  always_comb begin
    msg_next    = msg_reg;
    ctrl_next   = ctrl_reg;
    period_next = period_reg;
    tick_next   = tick_reg;
    offset_next = offset_reg;
    state_next  = state_reg;
    done_next   = done_reg;
    phase_next  = phase_reg;
    disp_load   = 1'b0;

    if (wr_msg) begin
      msg_next  = writedata;
      disp_load = 1'b1;
      if (state_reg == ST_SCROLL || state_reg == ST_HOLD) begin
        state_next  = ST_SCROLL;
        offset_next = 3'd0;
        tick_next   = '0;
        done_next   = 1'b0;
        phase_next  = 1'b0;
      end
    end else if (wr_ctrl) begin
      ctrl_next  = writedata[3:0] & CTRL_MASK;
      tick_next  = '0;
      done_next  = 1'b0;
      phase_next = 1'b0;
      disp_load  = 1'b1;
      if (!writedata[CTRL_RUN]) begin
        state_next = ST_IDLE;
      end else if (!writedata[CTRL_SCROLL]) begin
        state_next = ST_STATIC;
      end else begin
        state_next  = ST_SCROLL;
        offset_next = 3'd0;
      end
    end else if (wr_period) begin
      period_next = writedata[PERIOD_W-1:0];
      tick_next   = '0;
      disp_load   = 1'b1;
    end else if (state_reg == ST_SCROLL && period_reg != '0) begin
      if (period_last) begin
        tick_next = '0;
        disp_load = 1'b1;
        if (ctrl_reg[CTRL_WRAP]) begin
          offset_next = offset_reg + 3'd1;
        end else if (offset_reg >= 3'd3) begin
          // Last window of the message reached: freeze and flag completion
          offset_next = 3'd4;
          state_next  = ST_HOLD;
          done_next   = 1'b1;
        end else begin
          offset_next = offset_reg + 3'd1;
        end
      end else begin
        tick_next = tick_reg + PERIOD_W'(1);
      end
    end
`ifdef SEG7_BLINK_EN
    else if ((state_reg == ST_STATIC || state_reg == ST_HOLD) &&
             ctrl_reg[CTRL_BLINK] && period_reg != '0) begin
      if (period_last) begin
        tick_next  = '0;
        phase_next = !phase_reg;
        disp_load  = 1'b1;
      end else begin
        tick_next = tick_reg + PERIOD_W'(1);
      end
    end
`endif
  end

  // Per-digit window selection and font lookup on the next-state values
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [2:0] idx;
      logic [3:0] nib;
      logic [6:0] seg;
      assign idx = (state_next == ST_SCROLL || state_next == ST_HOLD)
                   ? offset_next + 3'(gi) : 3'(gi);
      assign nib = msg_next[{idx, 2'b00} +: 4];
      seg7_hex_font u_font (.nibble(nib), .segments(seg));
      assign disp_word[gi*8 +: 8] = {1'b0, seg};
    end
  endgenerate

  assign out_next = (state_next == ST_IDLE || phase_next) ? BLANK : disp_word;

  // State and register file; out_port refreshes only on a write or display event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msg_reg    <= '0;
      ctrl_reg   <= '0;
      period_reg <= '0;
      tick_reg   <= '0;
      offset_reg <= 3'd0;
      state_reg  <= ST_IDLE;
      done_reg   <= 1'b0;
      phase_reg  <= 1'b0;
      out_port   <= RESET_PATTERN;
    end else begin
      msg_reg    <= msg_next;
      ctrl_reg   <= ctrl_next;
      period_reg <= period_next;
      tick_reg   <= tick_next;
      offset_reg <= offset_next;
      state_reg  <= state_next;
      done_reg   <= done_next;
      phase_reg  <= phase_next;
      if (disp_load) out_port <= out_next;
    end
  end

  // Zero-wait combinational read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_MSG:    readdata = msg_reg;
      ADDR_CTRL:   readdata = {28'd0, ctrl_reg};
      ADDR_PERIOD: readdata = 32'(period_reg);
      default:     readdata = {25'd0, phase_reg, done_reg, state_reg, offset_reg};
    endcase
  end

endmodule
